dual_issue_ctrl: RTL and testbench
==================================

DUAL_ISSUE_CTRL -- requirements
Module: dual_issue_ctrl

Interface
REQ-001 CNT_W, default 16, width of the performance counters.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ifid_valid  in  1  IF/ID holds a valid instruction pair (lane A older, lane B younger).
REQ-005 a_op/b_op  in  7 each  decoded opcodes of lanes A/B.
REQ-006 a_rd, a_rs1, a_rs2, b_rd, b_rs1, b_rs2  in  5 each  decoded register fields.
REQ-007 idex_a_load, idex_b_load  in  1 each  ID/EX lane A/B holds a LOAD.
REQ-008 idex_a_rd, idex_b_rd  in  5 each  ID/EX lane A/B destination.
REQ-009 redirect  in  1  branch/JAL taken, resolved in EX this cycle.
REQ-010 issue_a, issue_b  out  1 each  lane A/B moves from ID into ID/EX this cycle.
REQ-011 ifid_hold  out  1  IF/ID and PC keep their values next edge.
REQ-012 idex_bubble  out  1  NOP written into the ID/EX lanes not issued.
REQ-013 flush  out  1  squash IF/ID and ID/EX contents.
REQ-014 state  out  2  FSM state: PAIR=0, B_ONLY=1, FLUSH=2.
REQ-015 stall_cnt, split_cnt  out  CNT_W each  saturating performance counters.

Function
REQ-016 Opcodes: LOAD 0000011, S_TYPE 0100011, B_TYPE 1100011, JAL 1101111, I_IMME 0010011, R_TYPE 0110011.
REQ-017 Writers (rd meaningful): R_TYPE, I_IMME, LOAD, JAL; rs1 used by R, I, LOAD, S, B; rs2 used by R, S, B.
REQ-018 Register match counts only when the source field is used, the destination is a writer's rd, and rd != 0.
REQ-019 hazA: (idex_a_load and idex_a_rd matches a source of A) or (idex_b_load and idex_b_rd matches a source of A).
REQ-020 hazB: same test applied to lane B sources.
REQ-021 split: A is LOAD and B sources match a_rd; or A and B both in {LOAD, S_TYPE}; or A is B_TYPE/JAL.
REQ-022 Outputs are combinational from state and inputs; state and counters update on clk rising edge.
REQ-023 redirect=1, any state: flush=1, issue_a=issue_b=0, ifid_hold=0, idex_bubble=1, next state FLUSH; overrides all other rules.
REQ-024 FLUSH: issue none, idex_bubble=1, ifid_hold=0, next state PAIR (drops the wrong-path pair fetched during the redirect cycle).
REQ-025 PAIR, ifid_valid=0: issue none, idex_bubble=1, ifid_hold=0, stay PAIR.
REQ-026 PAIR, hazA: issue none, ifid_hold=1, idex_bubble=1, stay PAIR.
REQ-027 PAIR, not hazA, (hazB or split): issue_a=1, issue_b=0, ifid_hold=1, idex_bubble=1 (lane B NOP), next B_ONLY.
REQ-028 PAIR, otherwise: issue_a=issue_b=1, ifid_hold=0, idex_bubble=0, stay PAIR.
REQ-029 B_ONLY, hazB (now checked against ID/EX holding A): issue none, ifid_hold=1, idex_bubble=1, stay B_ONLY.
REQ-030 B_ONLY, no hazB: issue_b=1, issue_a=0, ifid_hold=0, idex_bubble=1 (lane A NOP), next PAIR.
REQ-031 stall_cnt increments in every cycle with ifid_hold=1 and issue_a=issue_b=0; saturates at all-ones.
REQ-032 split_cnt increments on every PAIR->B_ONLY transition; saturates at all-ones.
REQ-033 Unencoded state value (3) behaves as FLUSH.

Reset
REQ-034 rst=1 at a clock edge: state=PAIR, stall_cnt=0, split_cnt=0.
REQ-035 While rst=1: issue_a=issue_b=0, ifid_hold=0, flush=0, idex_bubble=1, regardless of other inputs.
REQ-036 rst asserted in B_ONLY or FLUSH drops the pending lane; after release operation restarts in PAIR.

Verification
REQ-037 Independent pair A=R_TYPE x5, B=I_IMME x6 (rs1=x7) -> issue_a=issue_b=1, state stays PAIR, counters 0.
REQ-038 idex_a_load=1, idex_a_rd=3, A=R_TYPE rs1=x3 -> one cycle of no issue, stall_cnt=1, dual issue the next cycle.
REQ-039 A=LOAD rd=x4, B=R_TYPE rs2=x4 -> cycle 1 issue_a only, state B_ONLY, split_cnt=1; cycle 2 hazB stall; cycle 3 issue_b, state PAIR.
REQ-040 A=B_TYPE, B=R_TYPE, redirect=1 the cycle after A issues -> flush=1, no issue, state FLUSH then PAIR, B never issued.
REQ-041 CNT_W=4, hazA held 20 cycles -> stall_cnt reaches 15 and stays 15.
REQ-042 rst pulsed while in B_ONLY -> next cycle state=PAIR, counters 0, no issue_b for the dropped lane.

Source files
------------

// File: rtl/dual_issue_ctrl.sv
// Dual-issue ID-stage controller.
// The ID stage holds an instruction pair: lane A is the older instruction and lane B the younger.
// The controller chooses between dual issue, a split issue (A now, B on the next cycle) and a
// load-use stall. It also flushes the pipeline when EX resolves a taken branch or jump.
module dual_issue_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ifid_valid,
   input  logic [6:0]       a_op,
   input  logic [4:0]       a_rd,
   input  logic [4:0]       a_rs1,
   input  logic [4:0]       a_rs2,
   input  logic [6:0]       b_op,
   input  logic [4:0]       b_rd,
   input  logic [4:0]       b_rs1,
   input  logic [4:0]       b_rs2,
   input  logic             idex_a_load,
   input  logic [4:0]       idex_a_rd,
   input  logic             idex_b_load,
   input  logic [4:0]       idex_b_rd,
   input  logic             redirect,
   output logic             issue_a,
   output logic             issue_b,
   output logic             ifid_hold,
   output logic             idex_bubble,
   output logic             flush,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] split_cnt
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [1:0] {
      PAIR   = 2'd0,
      B_ONLY = 2'd1,
      FLUSH  = 2'd2,
      RSVD   = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic haz_a, haz_b, split;

   // Lane B's destination never feeds a decision: nothing inside the pair is younger than B.
   logic unused_b_rd;
   assign unused_b_rd = ^b_rd;

   function automatic logic uses_rs1(input logic [6:0] op);
      return (op == OP_REG) || (op == OP_IMM) || (op == OP_LOAD) ||
             (op == OP_STORE) || (op == OP_BRANCH);
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      return (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
   endfunction

   function automatic logic is_mem(input logic [6:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

   // The caller guarantees that rd belongs to a writer. Writes to x0 never create a dependency.
   function automatic logic src_match(input logic [6:0] op, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [4:0] rd);
      return (rd != '0) && ((uses_rs1(op) && (rs1 == rd)) || (uses_rs2(op) && (rs2 == rd)));
   endfunction

   // Hazard and split detection. A LOAD in ID/EX is always a writer.
   always_comb begin
      haz_a = (idex_a_load && src_match(a_op, a_rs1, a_rs2, idex_a_rd)) ||
              (idex_b_load && src_match(a_op, a_rs1, a_rs2, idex_b_rd));
      haz_b = (idex_a_load && src_match(b_op, b_rs1, b_rs2, idex_a_rd)) ||
              (idex_b_load && src_match(b_op, b_rs1, b_rs2, idex_b_rd));
      split = ((a_op == OP_LOAD) && src_match(b_op, b_rs1, b_rs2, a_rd)) ||
              (is_mem(a_op) && is_mem(b_op)) ||
              (a_op == OP_BRANCH) || (a_op == OP_JAL);
   end

   // Next-state and issue decisions. Reset overrides redirect, and redirect overrides everything else.
   always_comb begin
      issue_a     = 1'b0;
      issue_b     = 1'b0;
      ifid_hold   = 1'b0;
      idex_bubble = 1'b1;
      flush       = 1'b0;
      state_d     = state_q;
      if (rst) begin
         state_d = PAIR;
      end else if (redirect) begin
         flush   = 1'b1;
         state_d = FLUSH;
      end else begin
         case (state_q)
            PAIR: begin
               if (!ifid_valid) begin
                  state_d = PAIR;
               end else if (haz_a) begin
                  ifid_hold = 1'b1;
               end else if (haz_b || split) begin
                  issue_a   = 1'b1;
                  ifid_hold = 1'b1;
                  state_d   = B_ONLY;
               end else begin
                  issue_a     = 1'b1;
                  issue_b     = 1'b1;
                  idex_bubble = 1'b0;
               end
            end
            B_ONLY: begin
               if (haz_b) begin
                  ifid_hold = 1'b1;
               end else begin
                  issue_b = 1'b1;
                  state_d = PAIR;
               end
            end
            default: begin
               // FLUSH and the unencoded value both drop the wrong-path pair.
               state_d = PAIR;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= PAIR;
      else     state_q <= state_d;
   end

   assign state = state_q;

   // Saturating counters: full-stall cycles and PAIR->B_ONLY splits.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         split_cnt <= '0;
      end else begin
         if (ifid_hold && !issue_a && !issue_b && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if ((state_q == PAIR) && (state_d == B_ONLY) && (split_cnt != '1))
            split_cnt <= split_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Scoreboard bench for dual_issue_ctrl. The stimulus process pushes hand-computed
// expectations for each cycle, and a negedge monitor pops them and compares.
module tb_dual_issue_ctrl;

   localparam logic [6:0] LD = 7'b0000011;
   localparam logic [6:0] ST = 7'b0100011;
   localparam logic [6:0] BR = 7'b1100011;
   localparam logic [6:0] JL = 7'b1101111;
   localparam logic [6:0] IM = 7'b0010011;
   localparam logic [6:0] RR = 7'b0110011;

   logic        clk = 1'b0;
   logic        rst, ifid_valid, redirect;
   logic [6:0]  a_op, b_op;
   logic [4:0]  a_rd, a_rs1, a_rs2, b_rd, b_rs1, b_rs2;
   logic        idex_a_load, idex_b_load;
   logic [4:0]  idex_a_rd, idex_b_rd;
   logic        issue_a, issue_b, ifid_hold, idex_bubble, flush;
   logic [1:0]  state;
   logic [15:0] stall_cnt, split_cnt;
   logic        issue_a4, issue_b4, ifid_hold4, idex_bubble4, flush4;
   logic [1:0]  state4;
   logic [3:0]  stall_cnt4, split_cnt4;

   typedef struct {
      logic       ia, ib, h, bub, f;
      logic [1:0] st;
      int         stc, spc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc_n  = 0;

   dual_issue_ctrl dut (
      .clk(clk), .rst(rst), .ifid_valid(ifid_valid),
      .a_op(a_op), .a_rd(a_rd), .a_rs1(a_rs1), .a_rs2(a_rs2),
      .b_op(b_op), .b_rd(b_rd), .b_rs1(b_rs1), .b_rs2(b_rs2),
      .idex_a_load(idex_a_load), .idex_a_rd(idex_a_rd),
      .idex_b_load(idex_b_load), .idex_b_rd(idex_b_rd),
      .redirect(redirect),
      .issue_a(issue_a), .issue_b(issue_b), .ifid_hold(ifid_hold),
      .idex_bubble(idex_bubble), .flush(flush), .state(state),
      .stall_cnt(stall_cnt), .split_cnt(split_cnt)
   );

   dual_issue_ctrl #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .ifid_valid(ifid_valid),
      .a_op(a_op), .a_rd(a_rd), .a_rs1(a_rs1), .a_rs2(a_rs2),
      .b_op(b_op), .b_rd(b_rd), .b_rs1(b_rs1), .b_rs2(b_rs2),
      .idex_a_load(idex_a_load), .idex_a_rd(idex_a_rd),
      .idex_b_load(idex_b_load), .idex_b_rd(idex_b_rd),
      .redirect(redirect),
      .issue_a(issue_a4), .issue_b(issue_b4), .ifid_hold(ifid_hold4),
      .idex_bubble(idex_bubble4), .flush(flush4), .state(state4),
      .stall_cnt(stall_cnt4), .split_cnt(split_cnt4)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exv);
      checks++;
      if (act !== exv) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc_n, act, exv);
      end
   endtask

   // Monitor: every cycle that has a pending expectation is compared at the falling edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         cmp("issue_a", 32'(issue_a), 32'(e.ia));
         cmp("issue_b", 32'(issue_b), 32'(e.ib));
         cmp("ifid_hold", 32'(ifid_hold), 32'(e.h));
         cmp("idex_bubble", 32'(idex_bubble), 32'(e.bub));
         cmp("flush", 32'(flush), 32'(e.f));
         cmp("state", 32'(state), 32'(e.st));
         cmp("stall_cnt", 32'(stall_cnt), 32'(e.stc));
         cmp("split_cnt", 32'(split_cnt), 32'(e.spc));
         cmp("stall_cnt_w4", 32'(stall_cnt4), (e.stc > 15) ? 32'd15 : 32'(e.stc));
         cmp("split_cnt_w4", 32'(split_cnt4), (e.spc > 15) ? 32'd15 : 32'(e.spc));
      end
   end

   task automatic set_a(input logic [6:0] op, input logic [4:0] rd, rs1, rs2);
      a_op = op; a_rd = rd; a_rs1 = rs1; a_rs2 = rs2;
   endtask

   task automatic set_b(input logic [6:0] op, input logic [4:0] rd, rs1, rs2);
      b_op = op; b_rd = rd; b_rs1 = rs1; b_rs2 = rs2;
   endtask

   task automatic set_ex(input logic la, input logic [4:0] lard, input logic lb, input logic [4:0] lbrd);
      idex_a_load = la; idex_a_rd = lard; idex_b_load = lb; idex_b_rd = lbrd;
   endtask

   // Queue this cycle's expectation, then advance to just after the next rising edge.
   task automatic chk_cyc(input logic ia, ib, h, bub, f, input logic [1:0] st, input int stc, spc);
      exp_t e;
      e.ia = ia; e.ib = ib; e.h = h; e.bub = bub; e.f = f; e.st = st; e.stc = stc; e.spc = spc;
      exp_q.push_back(e);
      @(posedge clk); #1;
      cyc_n++;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; ifid_valid = 1'b1; redirect = 1'b1;
      set_a(RR, 5'd5, 5'd3, 5'd2);
      set_b(IM, 5'd6, 5'd7, 5'd0);
      set_ex(1'b1, 5'd3, 1'b0, 5'd0);
      @(posedge clk); #1;
      // Reset dominates both the redirect and the hazard.
      chk_cyc(0, 0, 0, 1, 0, 2'd0, 0, 0);
      rst = 1'b0; redirect = 1'b0;
      // Independent pair: dual issue.
      set_ex(1'b0, 5'd0, 1'b0, 5'd0);
      set_a(RR, 5'd5, 5'd1, 5'd2);
      chk_cyc(1, 1, 0, 0, 0, 2'd0, 0, 0);
      // No valid pair.
      ifid_valid = 1'b0;
      chk_cyc(0, 0, 0, 1, 0, 2'd0, 0, 0);
      ifid_valid = 1'b1;
      // Load-use on lane A: one stall, then dual issue.
      set_ex(1'b1, 5'd3, 1'b0, 5'd0);
      set_a(RR, 5'd5, 5'd3, 5'd2);
      chk_cyc(0, 0, 1, 1, 0, 2'd0, 0, 0);
      set_ex(1'b0, 5'd0, 1'b0, 5'd0);
      chk_cyc(1, 1, 0, 0, 0, 2'd0, 1, 0);
      // A load into x0 creates no hazard.
      set_ex(1'b1, 5'd0, 1'b0, 5'd0);
      set_a(RR, 5'd5, 5'd0, 5'd2);
      chk_cyc(1, 1, 0, 0, 0, 2'd0, 1, 0);
      // hazB from the ID/EX lane-B load: split the pair.
      set_ex(1'b0, 5'd0, 1'b1, 5'd9);
      set_a(RR, 5'd5, 5'd1, 5'd2);
      set_b(RR, 5'd6, 5'd1, 5'd9);
      chk_cyc(1, 0, 1, 1, 0, 2'd0, 1, 0);
      set_ex(1'b0, 5'd0, 1'b0, 5'd0);
      chk_cyc(0, 1, 0, 1, 0, 2'd1, 1, 1);
      // I_IMME does not read rs2, so there is no hazard.
      set_ex(1'b1, 5'd9, 1'b0, 5'd0);
      set_b(IM, 5'd6, 5'd1, 5'd9);
      chk_cyc(1, 1, 0, 0, 0, 2'd0, 1, 1);
      // A=LOAD x4 with B reading x4: split, hazB stall in B_ONLY, then issue B.
      set_ex(1'b0, 5'd0, 1'b0, 5'd0);
      set_a(LD, 5'd4, 5'd1, 5'd0);
      set_b(RR, 5'd6, 5'd2, 5'd4);
      chk_cyc(1, 0, 1, 1, 0, 2'd0, 1, 1);
      set_ex(1'b1, 5'd4, 1'b0, 5'd0);
      chk_cyc(0, 0, 1, 1, 0, 2'd1, 1, 2);
      set_ex(1'b0, 5'd0, 1'b0, 5'd0);
      chk_cyc(0, 1, 0, 1, 0, 2'd1, 2, 2);
      // Two memory operations split.
      set_a(ST, 5'd0, 5'd1, 5'd2);
      set_b(LD, 5'd7, 5'd3, 5'd0);
      chk_cyc(1, 0, 1, 1, 0, 2'd0, 2, 2);
      chk_cyc(0, 1, 0, 1, 0, 2'd1, 2, 3);
      // A branch splits, and a redirect while in B_ONLY drops lane B.
      set_a(BR, 5'd0, 5'd1, 5'd2);
      set_b(RR, 5'd6, 5'd3, 5'd4);
      chk_cyc(1, 0, 1, 1, 0, 2'd0, 2, 3);
      redirect = 1'b1;
      chk_cyc(0, 0, 0, 1, 1, 2'd1, 2, 4);
      redirect = 1'b0;
      chk_cyc(0, 0, 0, 1, 0, 2'd2, 2, 4);
      set_a(RR, 5'd5, 5'd1, 5'd2);
      set_b(IM, 5'd6, 5'd7, 5'd0);
      chk_cyc(1, 1, 0, 0, 0, 2'd0, 2, 4);
      // A redirect overrides a hazA stall and is not counted as a stall.
      set_ex(1'b1, 5'd3, 1'b0, 5'd0);
      set_a(RR, 5'd5, 5'd3, 5'd2);
      redirect = 1'b1;
      chk_cyc(0, 0, 0, 1, 1, 2'd0, 2, 4);
      redirect = 1'b0;
      set_ex(1'b0, 5'd0, 1'b0, 5'd0);
      chk_cyc(0, 0, 0, 1, 0, 2'd2, 2, 4);
      // A JAL in lane A splits.
      set_a(JL, 5'd1, 5'd0, 5'd0);
      set_b(RR, 5'd6, 5'd2, 5'd3);
      chk_cyc(1, 0, 1, 1, 0, 2'd0, 2, 4);
      chk_cyc(0, 1, 0, 1, 0, 2'd1, 2, 5);
      // Reset while in B_ONLY drops the pending lane.
      set_a(LD, 5'd4, 5'd1, 5'd0);
      set_b(RR, 5'd6, 5'd2, 5'd4);
      chk_cyc(1, 0, 1, 1, 0, 2'd0, 2, 5);
      rst = 1'b1;
      chk_cyc(0, 0, 0, 1, 0, 2'd1, 2, 6);
      rst = 1'b0; ifid_valid = 1'b0;
      chk_cyc(0, 0, 0, 1, 0, 2'd0, 0, 0);
      // hazA held for 20 cycles: the 4-bit counter saturates at 15.
      ifid_valid = 1'b1;
      set_ex(1'b1, 5'd3, 1'b0, 5'd0);
      set_a(RR, 5'd5, 5'd3, 5'd2);
      set_b(IM, 5'd6, 5'd7, 5'd0);
      for (int k = 0; k < 20; k++) chk_cyc(0, 0, 1, 1, 0, 2'd0, k, 0);
      set_ex(1'b0, 5'd0, 1'b0, 5'd0);
      chk_cyc(1, 1, 0, 0, 0, 2'd0, 20, 0);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
